// File: rtl/inst_loader.sv
// inst_loader: byte-stream program loader placed in front of simple_cpu.
// Accepts LEN_LO, LEN_HI (word count N), 4*N data bytes (words sent LSB first)
// and a trailing XOR checksum of the data bytes. Assembled 32-bit words are
// written to instruction memory from word address 0. The CPU is held in reset
// until the whole stream has been received and the checksum matched.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   in_valid/in_data   byte stream input; transfer on in_valid && in_ready
//   in_ready           loader can accept a byte
//   imem_we/addr/wdata registered one-cycle instruction memory write
//   cpu_rstn           active-low reset to the CPU, high only after a good load
//   load_done          sticky: load finished with a matching checksum
//   load_err           sticky: bad length or checksum mismatch
//   words_loaded       number of words written so far
module inst_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rstn,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_SUM, S_DONE, S_ERR
  } state_t;

  localparam logic [AW:0] WORD_ONE = 1;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   word_q, word_d;        // low three bytes of the word in flight
  logic [7:0]    xor_q, xor_d;
  logic [AW:0]   words_q, words_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          cpu_rstn_q, cpu_rstn_d;

  logic          fire;
  logic [15:0]   len_full;

  // ready_q already encodes "state is LEN0/LEN1/DATA/SUM", so it gates the handshake.
  assign fire     = in_valid && ready_q;
  assign len_full = {in_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    xor_d      = xor_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: state_d = S_LEN0;
      S_LEN0: begin
        if (fire) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (fire) begin
          len_d = len_full;
          if (len_full == 16'd0 || len_full > 16'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          xor_d      = xor_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          for (int b = 0; b < 3; b++) begin
            if (byte_idx_q == 2'(b)) begin
              word_d[8*b +: 8] = in_data;
            end
          end
          if (byte_idx_q == 2'd3) begin
            // Fourth byte completes the word: write it at the current count.
            we_d    = 1'b1;
            addr_d  = words_q[AW-1:0];
            wdata_d = {in_data, word_q};
            words_d = words_q + WORD_ONE;
            if (16'(words_q) + 16'd1 == len_q) begin
              state_d = S_SUM;
            end
          end
        end
      end
      S_SUM: begin
        if (fire) begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they change on the
    // same edge as the state transition that causes them.
    ready_d    = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                 (state_d == S_DATA) || (state_d == S_SUM);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_rstn_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      xor_q      <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rstn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      xor_q      <= xor_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rstn_q <= cpu_rstn_d;
    end
  end

  assign in_ready     = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rstn     = cpu_rstn_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader. A byte-position model predicts every
// output each cycle; literal checks pin the documented example streams.
module tb_inst_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rstn;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  inst_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rstn(cpu_rstn), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (by byte position in the stream) -----
  bit          e_ready, e_we, e_cpu, e_done, e_err;
  int          e_words;
  logic [31:0] e_addr, e_wdata;
  int          m_cnt, m_n;
  logic [7:0]  m_lo, m_xor;
  logic [31:0] m_word;
  bit          m_started;

  initial forever begin
    @(posedge clk);
    e_we = 0;
    if (!rstn) begin
      e_ready = 0; e_cpu = 0; e_done = 0; e_err = 0; e_words = 0;
      e_addr = 0; e_wdata = 0;
      m_cnt = 0; m_n = 0; m_lo = 0; m_xor = 0; m_word = 0; m_started = 0;
    end else if (!m_started) begin
      m_started = 1;
      e_ready = 1;
    end else if (e_ready && in_valid) begin
      int p, k;
      p = m_cnt;
      m_cnt++;
      if (p == 0) begin
        m_lo = in_data;
      end else if (p == 1) begin
        m_n = int'(in_data) * 256 + int'(m_lo);
        if (m_n == 0 || m_n > DEPTH) begin
          e_err = 1; e_ready = 0;
        end
      end else if (p < 2 + 4 * m_n) begin
        k = p - 2;
        m_xor = m_xor ^ in_data;
        if (k % 4 == 0) m_word = 0;
        m_word = m_word | (32'(in_data) << (8 * (k % 4)));
        if (k % 4 == 3) begin
          e_we = 1; e_addr = k / 4; e_wdata = m_word; e_words = k / 4 + 1;
        end
      end else begin
        e_ready = 0;
        if (in_data == m_xor) begin
          e_done = 1; e_cpu = 1;
        end else begin
          e_err = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare + write capture ----------------------
  logic [31:0] mem [DEPTH];
  int          we_count = 0;

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("imem_we", 32'(imem_we), 32'(e_we));
      chk("cpu_rstn", 32'(cpu_rstn), 32'(e_cpu));
      chk("load_done", 32'(load_done), 32'(e_done));
      chk("load_err", 32'(load_err), 32'(e_err));
      chk("words_loaded", 32'(words_loaded), 32'(e_words));
      if (e_we) begin
        chk("imem_addr", 32'(imem_addr), e_addr);
        chk("imem_wdata", imem_wdata, e_wdata);
      end
    end
    if (imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      we_count++;
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    in_valid = 0;
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'hDEADBEEF;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap, waitc;
    bit hs;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 0;
    end
    waitc = 0;
    hs = 0;
    while (!hs && waitc < 20) begin
      @(negedge clk);
      in_valid = 1;
      in_data = b;
      hs = in_ready;
      @(posedge clk);
      waitc++;
    end
    chk("handshake", 32'(hs), 32'd1);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int max_gap);
    foreach (s[i]) send_byte(s[i], max_gap);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
  endtask

  // Offer bytes to a loader that has finished; none may be accepted.
  task automatic offer_after();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ready_after_end", 32'(in_ready), 32'd0);
      in_valid = 1;
      in_data = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic build_stream(input int n, input logic [31:0] base, input bit random_words,
                              input bit corrupt, output logic [7:0] s[$]);
    logic [7:0]  x;
    logic [31:0] w;
    s = {};
    x = 0;
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    for (int k = 0; k < n; k++) begin
      w = random_words ? $urandom : base + 32'(k);
      for (int j = 0; j < 4; j++) begin
        s.push_back(w[8*j +: 8]);
        x = x ^ w[8*j +: 8];
      end
    end
    s.push_back(corrupt ? ~x : x);
  endtask

  task automatic report(input int id);
    $display("load %0d: done=%0b err=%0b cpu_rstn=%0b words=%0d", id,
             load_done, load_err, cpu_rstn, words_loaded);
  endtask

  // ---------------- main sequence -----------------------------------------
  logic [7:0] good[$];
  logic [7:0] bad_sum[$];
  logic [7:0] strm[$];
  int         wc0;

  initial begin
    good = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
            8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
    bad_sum = good;
    bad_sum[10] = 8'hC0;

    rstn = 0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    // Reset values while rstn is still low.
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    rstn = 1;
    @(negedge clk);
    chk("ready_after_idle", 32'(in_ready), 32'd1);

    // Good load, no gaps.
    clear_mem();
    wc0 = we_count;
    send_stream(good, 0);
    chk("good_mem0", mem[0], 32'h00500093);
    chk("good_mem1", mem[1], 32'h00100113);
    chk("good_words", 32'(words_loaded), 32'd2);
    chk("good_done", 32'(load_done), 32'd1);
    chk("good_cpu_rstn", 32'(cpu_rstn), 32'd1);
    chk("good_we_count", 32'(we_count - wc0), 32'd2);
    offer_after();
    chk("after_done_words", 32'(words_loaded), 32'd2);
    report(1);

    // Bad checksum.
    do_reset();
    wc0 = we_count;
    send_stream(bad_sum, 0);
    chk("badsum_err", 32'(load_err), 32'd1);
    chk("badsum_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("badsum_ready", 32'(in_ready), 32'd0);
    chk("badsum_we_count", 32'(we_count - wc0), 32'd2);
    report(2);

    // Bad lengths: 0 and DEPTH+1.
    do_reset();
    wc0 = we_count;
    strm = {8'h00, 8'h00};
    send_stream(strm, 0);
    offer_after();
    chk("len0_err", 32'(load_err), 32'd1);
    chk("len0_we_count", 32'(we_count - wc0), 32'd0);
    report(3);

    do_reset();
    wc0 = we_count;
    strm = {8'h41, 8'h00};
    send_stream(strm, 0);
    offer_after();
    chk("len65_err", 32'(load_err), 32'd1);
    chk("len65_we_count", 32'(we_count - wc0), 32'd0);
    report(4);

    // Good load with random idle gaps between bytes.
    do_reset();
    clear_mem();
    send_stream(good, 5);
    chk("gap_mem0", mem[0], 32'h00500093);
    chk("gap_mem1", mem[1], 32'h00100113);
    chk("gap_done", 32'(load_done), 32'd1);
    offer_after();
    report(5);

    // Full depth.
    do_reset();
    clear_mem();
    build_stream(DEPTH, 32'h1000_0000, 0, 0, strm);
    send_stream(strm, 0);
    for (int k = 0; k < DEPTH; k++) chk("full_mem", mem[k], 32'h1000_0000 + 32'(k));
    chk("full_words", 32'(words_loaded), 32'd64);
    chk("full_done", 32'(load_done), 32'd1);
    report(6);

    // Reset mid-load after 5 bytes, then a complete good stream.
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(good[i], 0);
    do_reset();
    in_valid = 0;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_words", 32'(words_loaded), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_done", 32'(load_done), 32'd0);
    clear_mem();
    send_stream(good, 2);
    chk("mid_mem0", mem[0], 32'h00500093);
    chk("mid_mem1", mem[1], 32'h00100113);
    chk("mid_done", 32'(load_done), 32'd1);
    report(7);

    // Randomized loads: random length, contents, gaps and checksum corruption.
    for (int it = 0; it < 6; it++) begin
      int  n;
      bit  corrupt;
      n = int'($urandom_range(DEPTH, 1));
      corrupt = ($urandom_range(2, 0) == 0);
      do_reset();
      clear_mem();
      build_stream(n, 32'h0, 1, corrupt, strm);
      send_stream(strm, 3);
      chk("rand_done", 32'(load_done), 32'(!corrupt));
      chk("rand_err", 32'(load_err), 32'(corrupt));
      chk("rand_words", 32'(words_loaded), 32'(n));
      for (int k = 0; k < n; k++) begin
        chk("rand_mem", mem[k], {strm[2+4*k+3], strm[2+4*k+2], strm[2+4*k+1], strm[2+4*k]});
      end
      report(8 + it);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
